// File: rtl/movavg_pkg.sv
// Shared definitions for the 4-tap moving-sum filter and its inverse.
// Optional sample counter in movavg_inv is enabled with MOVINV_COUNT_EN.
package movavg_pkg;

    localparam int DEFAULT_WL    = 64;
    localparam int DEFAULT_NTAPS = 4;

    typedef logic [DEFAULT_WL-1:0] word_t;
    typedef word_t [DEFAULT_NTAPS-1:1] hist_t;

endpackage

// File: rtl/movavg_hist.sv
// Shift register of recovered samples; tap 1 is the newest, tap DEPTH the oldest.
module movavg_hist
    import movavg_pkg::*;
#(
    parameter int WL    = DEFAULT_WL,
    parameter int DEPTH = DEFAULT_NTAPS
) (
    input  logic          clk,
    input  logic          flush_i,
    input  logic          shift_i,
    input  logic [WL-1:0] din_i,
    output logic [WL-1:0] oldest_o
);

    generate
        for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_tap
            logic [WL-1:0] tap_q;
            logic [WL-1:0] tap_d;

            if (gi == 1) begin : g_head
                assign tap_d = din_i;
            end else begin : g_body
                assign tap_d = g_tap[gi-1].tap_q;
            end

            always_ff @(posedge clk) begin
                if (flush_i) begin
                    tap_q <= '0;
                end else if (shift_i) begin
                    tap_q <= tap_d;
                end
            end
        end
    endgenerate

    assign oldest_o = g_tap[DEPTH].tap_q;

endmodule

// File: rtl/movavg_inv.sv
// Inverse of the NTAPS moving-sum filter: x[n] = y[n] - y[n-1] + x[n-NTAPS].
// Define MOVINV_COUNT_EN to add the sample_cnt / primed status outputs.
module movavg_inv
    import movavg_pkg::*;
#(
    parameter int WL    = DEFAULT_WL,
    parameter int NTAPS = DEFAULT_NTAPS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [WL-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [WL-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready
`ifdef MOVINV_COUNT_EN
    ,
    output logic [31:0]   sample_cnt,
    output logic          primed
`endif
);

    logic          flush;
    logic          accept;
    logic [WL-1:0] x_old;
    logic [WL-1:0] x_new;
    logic [WL-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic [WL-1:0] y_prev_q, y_prev_d;

    assign flush     = reset | clear;
    assign din_ready = !dout_valid_q || dout_ready;
    assign accept    = din_valid && din_ready && !flush;
    assign x_new     = din - y_prev_q + x_old;

    // y[n]-y[n-1] leaves x[n]-x[n-NTAPS], so the history must reach back NTAPS samples.
    movavg_hist #(
        .WL    (WL),
        .DEPTH (NTAPS)
    ) u_hist (
        .clk      (clk),
        .flush_i  (flush),
        .shift_i  (accept),
        .din_i    (x_new),
        .oldest_o (x_old)
    );

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        y_prev_d     = y_prev_q;
        if (accept) begin
            dout_d       = x_new;
            dout_valid_d = 1'b1;
            y_prev_d     = din;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            y_prev_q     <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            y_prev_q     <= y_prev_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

`ifdef MOVINV_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = accept ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (flush) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_cnt = cnt_q;
    assign primed     = (cnt_q >= 32'(NTAPS - 1));
`endif

endmodule

// File: tb/tb_movavg_inv.sv
// Directed bench for movavg_inv, ending with a forward-filter round trip.
module tb_movavg_inv;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALLE = 64'hFFFF_FFFF_FFFF_FFFE;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
`ifdef MOVINV_COUNT_EN
    logic [31:0] sample_cnt;
    logic        primed;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    movavg_inv dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef MOVINV_COUNT_EN
        ,
        .sample_cnt (sample_cnt),
        .primed     (primed)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present y with valid high for one edge, then check the recovered sample.
    task automatic push(input string tag, input logic [63:0] y, input logic [63:0] x_exp);
        din       = y;
        din_valid = 1'b1;
        tick();
        check(tag, dout, x_exp);
        check({tag, "_vld"}, {63'd0, dout_valid}, 64'd1);
    endtask

    task automatic idle();
        din_valid = 1'b0;
        tick();
    endtask

    logic [63:0] xh [0:3];
    logic [63:0] xr;

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_dout", dout, 64'd0);
        check("rst_vld", {63'd0, dout_valid}, 64'd0);
        check("rst_rdy", {63'd0, din_ready}, 64'd1);
`ifdef MOVINV_COUNT_EN
        check("rst_cnt", {32'd0, sample_cnt}, 64'd0);
        check("rst_primed", {63'd0, primed}, 64'd0);
`endif
        reset = 1'b0;

        // Back-to-back stream
        push("s0", 64'd1, 64'd1);
`ifdef MOVINV_COUNT_EN
        check("primed1", {63'd0, primed}, 64'd0);
`endif
        push("s1", 64'd3, 64'd2);
`ifdef MOVINV_COUNT_EN
        check("primed2", {63'd0, primed}, 64'd0);
`endif
        push("s2", 64'd6, 64'd3);
`ifdef MOVINV_COUNT_EN
        check("primed3", {63'd0, primed}, 64'd1);
`endif
        push("s3", 64'd10, 64'd4);
        push("s4", 64'd14, 64'd5);
        push("s5", 64'd18, 64'd6);
        idle();
        check("drain_vld", {63'd0, dout_valid}, 64'd0);

        // Modular wraparound
        do_reset();
        push("wrap0", ALL1, ALL1);
        push("wrap1", ALLE, ALL1);
        idle();

        // Backpressure for three cycles mid-stream
        do_reset();
        push("bp0", 64'd1, 64'd1);
        push("bp1", 64'd3, 64'd2);
        dout_ready = 1'b0;
        din        = 64'd6;
        din_valid  = 1'b1;
        #1;
        check("bp_rdy_lo", {63'd0, din_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", dout, 64'd2);
            check("bp_hold_vld", {63'd0, dout_valid}, 64'd1);
            check("bp_hold_rdy", {63'd0, din_ready}, 64'd0);
        end
        dout_ready = 1'b1;
        #1;
        check("bp_rdy_hi", {63'd0, din_ready}, 64'd1);
        push("bp2", 64'd6, 64'd3);
        push("bp3", 64'd10, 64'd4);
        push("bp4", 64'd14, 64'd5);
        idle();

        // Gaps between inputs
        do_reset();
        push("gap0", 64'd1, 64'd1);
        idle();
        check("gap0_idle", {63'd0, dout_valid}, 64'd0);
        push("gap1", 64'd3, 64'd2);
        idle();
        check("gap1_idle", {63'd0, dout_valid}, 64'd0);
        push("gap2", 64'd6, 64'd3);
        idle();
        push("gap3", 64'd10, 64'd4);
        idle();

        // Clear flushes history
        do_reset();
        push("clr0", 64'd1, 64'd1);
        push("clr1", 64'd3, 64'd2);
        push("clr2", 64'd6, 64'd3);
        din_valid = 1'b0;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_vld", {63'd0, dout_valid}, 64'd0);
        check("clr_dout", dout, 64'd0);
        push("clr3", 64'd5, 64'd5);
        push("clr4", 64'd12, 64'd7);

        // Clear together with valid input drops that input
        din       = 64'd99;
        din_valid = 1'b1;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        check("clrv_vld", {63'd0, dout_valid}, 64'd0);
        push("clrv_next", 64'd4, 64'd4);
        idle();

        // Round trip through a forward moving-sum model
        do_reset();
        for (int k = 0; k < 4; k++) xh[k] = '0;
        for (int n = 0; n < 1024; n++) begin
            xr    = {$urandom(), $urandom()};
            xh[3] = xh[2];
            xh[2] = xh[1];
            xh[1] = xh[0];
            xh[0] = xr;
            din       = xh[0] + xh[1] + xh[2] + xh[3];
            din_valid = 1'b1;
            tick();
            check("rt", dout, xr);
        end
        idle();
`ifdef MOVINV_COUNT_EN
        check("rt_cnt", {32'd0, sample_cnt}, 64'd1024);
        check("rt_primed", {63'd0, primed}, 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
